// File: rtl/lb_master.sv
// Local-bus initiator: one valid/ready command in, one strobe on the local bus,
// one valid/ready response out (bus data, write ack or timeout marker).
module lb_master #(
  parameter int unsigned          LB_DATA_W        = 32,
  parameter int unsigned          LB_ADDR_W        = 16,
  parameter int unsigned          TIMEOUT_CYCLES   = 256,
  parameter logic [LB_DATA_W-1:0] TIMEOUT_DATA_VAL = 'hdeadbabe
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_wr,
  input  logic [LB_ADDR_W-1:0] cmd_addr,
  input  logic [LB_DATA_W-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_wr,
  output logic                 rsp_timeout,
  output logic [LB_DATA_W-1:0] rsp_rdata,
  output logic                 lb_wr_en,
  output logic                 lb_rd_en,
  output logic [LB_ADDR_W-1:0] lb_addr,
  output logic [LB_DATA_W-1:0] lb_wr_data,
  input  logic                 lb_wr_valid,
  input  logic                 lb_rd_valid,
  input  logic [LB_DATA_W-1:0] lb_rd_data
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic             cur_wr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             match;

  always_comb begin
    match    = cur_wr ? lb_wr_valid : lb_rd_valid;
    cnt_next = (cnt == CNT_W'(TIMEOUT_CYCLES)) ? cnt : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_wr      <= 1'b0;
      cnt         <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_wr      <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
      lb_wr_en    <= 1'b0;
      lb_rd_en    <= 1'b0;
      lb_addr     <= '0;
      lb_wr_data  <= '0;
    end else begin
      lb_wr_en <= 1'b0;
      lb_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready  <= 1'b0;
            cur_wr     <= cmd_wr;
            lb_addr    <= cmd_addr;
            lb_wr_data <= cmd_wdata;
            lb_wr_en   <= cmd_wr;
            lb_rd_en   <= !cmd_wr;
            state      <= ISSUE;
          end
        end
        // ISSUE and WAIT share completion logic; the counter restarts in ISSUE
        // and timeout is only possible from WAIT, with a matching valid winning.
        ISSUE, WAIT: begin
          cnt <= (state == ISSUE) ? '0 : cnt_next;
          if (match) begin
            rsp_valid   <= 1'b1;
            rsp_wr      <= cur_wr;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= cur_wr ? '0 : lb_rd_data;
            state       <= RESP;
          end else if (state == WAIT && cnt_next == CNT_W'(TIMEOUT_CYCLES)) begin
            rsp_valid   <= 1'b1;
            rsp_wr      <= cur_wr;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= TIMEOUT_DATA_VAL;
            state       <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lb_master.sv
// Directed bench for lb_master with an 8-cycle timeout: vector table plus
// hand-written backpressure/timeout-hold and mid-transaction reset sequences.
module tb_lb_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_wr;
  logic        rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        lb_wr_en;
  logic        lb_rd_en;
  logic [15:0] lb_addr;
  logic [31:0] lb_wr_data;
  logic        lb_wr_valid;
  logic        lb_rd_valid;
  logic [31:0] lb_rd_data;

  int total = 0;
  int bad   = 0;

  lb_master #(
    .LB_DATA_W(32),
    .LB_ADDR_W(16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_wr(rsp_wr),
    .rsp_timeout(rsp_timeout),
    .rsp_rdata(rsp_rdata),
    .lb_wr_en(lb_wr_en),
    .lb_rd_en(lb_rd_en),
    .lb_addr(lb_addr),
    .lb_wr_data(lb_wr_data),
    .lb_wr_valid(lb_wr_valid),
    .lb_rd_valid(lb_rd_valid),
    .lb_rd_data(lb_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // vk: offset from the enable cycle E of the matching valid (-1 = none)
  // sk: offset of a non-matching stray valid (-1 = none)
  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          vk;
    int          sk;
    logic [31:0] bus_data;
    int          lat;
    logic        exp_to;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   k;
    int   en_cnt;
    bit   got;
    v = vecs[i];
    wait_ready();
    cmd_valid = 1'b1;
    cmd_wr    = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    tick();
    cmd_valid = 1'b0;
    check("issue_en", 32'({lb_wr_en, lb_rd_en}), v.wr ? 32'd2 : 32'd1);
    check("issue_addr", 32'(lb_addr), 32'(v.addr));
    if (v.wr) check("issue_wdata", lb_wr_data, v.wdata);
    check("busy_cmd_ready", 32'(cmd_ready), 32'd0);
    check("early_rsp_valid", 32'(rsp_valid), 32'd0);
    k = 0;
    en_cnt = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      en_cnt += int'(lb_wr_en) + int'(lb_rd_en);
      lb_wr_valid = (k == v.vk && v.wr) || (k == v.sk && !v.wr);
      lb_rd_valid = (k == v.vk && !v.wr) || (k == v.sk && v.wr);
      lb_rd_data  = (k == v.vk || k == v.sk) ? v.bus_data : 32'h0;
      tick();
      lb_wr_valid = 1'b0;
      lb_rd_valid = 1'b0;
      lb_rd_data  = 32'h0;
      k++;
      got = rsp_valid;
    end
    check("latency", k, v.lat);
    check("enable_pulses", en_cnt, 1);
    check("resp_enables_low", 32'({lb_wr_en, lb_rd_en}), 32'd0);
    check("rsp_wr", 32'(rsp_wr), 32'(v.wr));
    check("rsp_timeout", 32'(rsp_timeout), 32'(v.exp_to));
    check("rsp_rdata", rsp_rdata, v.exp_rdata);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("ready_after_rsp", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int  k;
    bit  seen;

    vecs[0] = '{1'b1, 16'h1004, 32'h12345678, 0, -1, 32'hFFFFFFFF, 1, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 16'h2010, 32'h0,        5,  2, 32'hCAFEF00D, 6, 1'b0, 32'hCAFEF00D};
    vecs[2] = '{1'b0, 16'h0030, 32'h0,       -1, -1, 32'h11111111, 9, 1'b1, 32'hDEADBABE};
    vecs[3] = '{1'b0, 16'h0044, 32'h0,        8, -1, 32'h5555AAAA, 9, 1'b0, 32'h5555AAAA};
    vecs[4] = '{1'b1, 16'hFFFC, 32'hA5A5A5A5, 8, -1, 32'hFFFFFFFF, 9, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 16'h0000, 32'h00000001, -1, 3, 32'h77777777, 9, 1'b1, 32'hDEADBABE};
    vecs[6] = '{1'b0, 16'h8000, 32'h0,        0, -1, 32'h87654321, 1, 1'b0, 32'h87654321};
    vecs[7] = '{1'b1, 16'h1234, 32'hDEAD0001, 3,  1, 32'h0BADF00D, 4, 1'b0, 32'h0};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr = 1'b0;
    cmd_addr = 16'h0;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    lb_wr_valid = 1'b0;
    lb_rd_valid = 1'b0;
    lb_rd_data = 32'h0;

    tick();
    tick();
    check("reset_ctrl", 32'({cmd_ready, rsp_valid, rsp_wr, rsp_timeout, lb_wr_en, lb_rd_en}), 32'd0);
    check("reset_data", rsp_rdata | lb_wr_data | 32'(lb_addr), 32'd0);
    rst = 1'b0;
    check("ready_before_edge", 32'(cmd_ready), 32'd0);
    tick();
    check("ready_first_edge", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Timeout response held under backpressure while a new command waits
    wait_ready();
    cmd_valid = 1'b1;
    cmd_wr = 1'b0;
    cmd_addr = 16'h00AA;
    tick();
    cmd_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 40) begin
      tick();
      k++;
    end
    check("bp_timeout_latency", k, 9);
    cmd_valid = 1'b1;
    cmd_wr = 1'b1;
    cmd_addr = 16'h0BEE;
    cmd_wdata = 32'h600DCAFE;
    for (int c = 0; c < 10; c++) begin
      check("bp_hold_ctrl", 32'({rsp_valid, rsp_wr, rsp_timeout, cmd_ready, lb_wr_en, lb_rd_en}),
            32'b101000);
      check("bp_hold_rdata", rsp_rdata, 32'hDEADBABE);
      lb_rd_valid = (c == 1);
      lb_rd_data  = (c == 1) ? 32'h13572468 : 32'h0;
      tick();
      lb_rd_valid = 1'b0;
      lb_rd_data  = 32'h0;
    end
    check("bp_hold_end", 32'({rsp_valid, rsp_timeout, cmd_ready}), 32'b110);
    check("bp_hold_end_rdata", rsp_rdata, 32'hDEADBABE);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_release_ready", 32'({cmd_ready, rsp_valid}), 32'b10);
    tick();
    cmd_valid = 1'b0;
    check("bp_next_issue", 32'({lb_wr_en, lb_rd_en}), 32'd2);
    check("bp_next_addr", 32'(lb_addr), 32'h0BEE);
    check("bp_next_wdata", lb_wr_data, 32'h600DCAFE);
    lb_wr_valid = 1'b1;
    tick();
    lb_wr_valid = 1'b0;
    check("bp_next_rsp", 32'({rsp_valid, rsp_wr, rsp_timeout}), 32'b110);
    check("bp_next_rdata", rsp_rdata, 32'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset three cycles into WAIT
    wait_ready();
    cmd_valid = 1'b1;
    cmd_wr = 1'b0;
    cmd_addr = 16'h0ABC;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rst_async_ctrl", 32'({cmd_ready, rsp_valid, rsp_wr, rsp_timeout, lb_wr_en, lb_rd_en}), 32'd0);
    check("rst_async_addr", 32'(lb_addr), 32'd0);
    check("rst_async_data", rsp_rdata | lb_wr_data, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      lb_rd_valid = (c == 4);
      lb_rd_data  = (c == 4) ? 32'h24681357 : 32'h0;
      tick();
      lb_rd_valid = 1'b0;
      lb_rd_data  = 32'h0;
      if (rsp_valid) seen = 1'b1;
    end
    check("no_rsp_after_rst", 32'(seen), 32'd0);
    check("ready_after_rst", 32'(cmd_ready), 32'd1);
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
